traffic_light_monitor: RTL
==========================

# traffic_light_monitor

Passive checker that observes the red/yellow/green outputs of a one-way traffic light controller and decodes them back into the controller's phase. It measures how long each phase lasts and flags illegal light patterns, out-of-order phase transitions and phase-duration violations. It sits beside the controller in simulation and on-chip self-test, and never drives the lights.

## Interface
- RED_CYC, 30: required STOP (red only) duration, in clock cycles.
- YEL_CYC, 3: required duration of READY_TO_GO (red+yellow) and READY_TO_STOP (yellow only), in cycles.
- GRN_CYC, 30: required GO (green only) duration, in cycles.
- TOL, 0: allowed deviation in cycles, applied symmetrically (±TOL).
- CW, 16: width of the duration counter. Must satisfy 2^CW-1 > max(RED_CYC, GRN_CYC)+TOL+1.

Ports:
- clk  in  1  single clock; all flops on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- red, yellow, green  in  1 each  light outputs under observation; synchronous to clk.
- clr  in  1  synchronous clear of err_flags and err_count.
- phase  out  3  decoded phase: 0 OFF, 1 STOP, 2 READY_TO_GO, 3 GO, 4 READY_TO_STOP, 7 ILLEGAL.
- dur  out  CW  cycles spent so far in the current phase; saturating.
- err_seq  out  1  one-cycle pulse on an illegal transition.
- err_time  out  1  one-cycle pulse on a duration violation.
- err_illegal  out  1  one-cycle pulse on entry to the ILLEGAL phase.
- err_flags  out  3  sticky {illegal, seq, time}.
- err_count  out  8  saturating total of error pulses.

## Operation
- Stage 1: lights_q <= {red, yellow, green}.
- Combinational decode of lights_q:
  - 000 OFF, 100 STOP, 110 READY_TO_GO, 001 GO, 010 READY_TO_STOP.
  - Any other pattern is ILLEGAL.
- Stage 2: phase holds the decoded value.
  - On a change: phase <= new value and dur <= 1.
  - Otherwise: dur <= dur+1, saturating at 2^CW-1.
- Legal transitions: OFF→STOP, STOP→RTG, RTG→GO, GO→RTS, RTS→STOP, and any phase→OFF. Any other change between two non-ILLEGAL phases pulses err_seq.
- ILLEGAL handling:
  - Entry pulses err_illegal.
  - Transitions into or out of ILLEGAL never pulse err_seq.
  - The first phase entered after ILLEGAL is unsynced: no time checks are made on it.
- Expected duration E per phase:
  - STOP: RED_CYC.
  - RTG and RTS: YEL_CYC.
  - GO: GRN_CYC.
  - OFF and ILLEGAL are unchecked.
- Long-duration check: the edge at which dur becomes E+TOL+1 pulses err_time once and marks the phase as reported.
- Short-duration check, made on phase exit:
  - If the phase is not reported and dur < E-TOL, pulse err_time.
  - Skip this check when TOL ≥ E.
- A seq error and a time error may pulse in the same cycle.
- err_flags:
  - Each pulse sets its sticky bit.
  - clr clears all bits, but a pulse in the same cycle wins (its bit stays set).
- err_count:
  - Adds the number of pulses asserted that cycle (0–3), saturating at 255.
  - clr sets it to 0 and drops that cycle's pulses.

## Timing
- Reset (async, while rst_n=0):
  - lights_q=000, phase=OFF, dur=0.
  - All pulses 0, err_flags=0, err_count=0.
  - The unsynced/reported markers are cleared.
- Latency:
  - A pattern present before edge k is captured into lights_q at edge k.
  - phase, dur and any err_* pulse update at edge k+1, so outputs lag the inputs by 2 edges.
  - err_flags and err_count update at the same edge as the pulse.
- Pulses are registered and last exactly one cycle.
- Timing-critical boundaries:
  - Duration is counted in sampled cycles. A pattern held N cycles gives dur=N at exit.
  - dur=E-TOL at exit passes. dur=E-TOL-1 fails.
  - dur reaching E+TOL passes. dur reaching E+TOL+1 fails.
  - A reported phase produces no second err_time on exit.
- Reset mid-operation:
  - Outputs return to their reset values immediately.
  - After release, the first non-OFF phase is checked against OFF. OFF→GO, for example, pulses err_seq.

## Test plan
- Nominal run (defaults):
  - Stimulus: 000 for 5 cycles, then STOP 30, RTG 3, GO 30, RTS 3, repeated for 2 loops.
  - Response: phase steps 0,1,2,3,4,1,… with a 2-edge lag; no pulses; err_count=0.
- Short yellow:
  - Stimulus: RTG held 2 cycles, then GO.
  - Response: one err_time pulse at the GO entry edge; err_flags=001; err_count=1.
- Stuck green:
  - Stimulus: GO held 40 cycles, then RTS 3.
  - Response: err_time pulses once, when dur=31; nothing at exit; err_count=1.
- Skipped phase:
  - Stimulus: STOP 30 → GO.
  - Response: err_seq pulses once, no err_time; err_flags=010; err_count=1.
- Illegal pattern and clear:
  - Stimulus: 111 for 2 cycles, then STOP 10, then RTG 3.
  - Response: err_illegal pulses once; phase=7; no err_time for the 10-cycle STOP.
  - Then assert clr with no errors pending: err_flags=0 and err_count=0 next edge.
- Async reset mid-GO:
  - Stimulus: drop rst_n between edges.
  - Response: all outputs 0 without a clock edge.
  - Then release rst_n with 001 held: err_seq pulses 2 edges later (OFF→GO).

Source files
------------

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker for a one-way traffic light.
// Decodes {red, yellow, green} back into the controller phase. It measures
// how long each phase lasts and flags illegal patterns, out-of-order
// transitions and duration violations.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   red, yellow, green    observed lights (synchronous to clk)
//   clr                   sync clear of err_flags / err_count
//   phase                 decoded phase (0 OFF,1 STOP,2 RTG,3 GO,4 RTS,7 ILLEGAL)
//   dur                   cycles in current phase, saturating
//   err_seq/time/illegal  one-cycle error pulses
//   err_flags             sticky {illegal, seq, time}
//   err_count             saturating count of error pulses
module traffic_light_monitor #(
  parameter int unsigned RED_CYC = 30,
  parameter int unsigned YEL_CYC = 3,
  parameter int unsigned GRN_CYC = 30,
  parameter int unsigned TOL     = 0,
  parameter int unsigned CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          red,
  input  logic          yellow,
  input  logic          green,
  input  logic          clr,
  output logic [2:0]    phase,
  output logic [CW-1:0] dur,
  output logic          err_seq,
  output logic          err_time,
  output logic          err_illegal,
  output logic [2:0]    err_flags,
  output logic [7:0]    err_count
);

  typedef enum logic [2:0] {
    PH_OFF  = 3'd0,
    PH_STOP = 3'd1,
    PH_RTG  = 3'd2,
    PH_GO   = 3'd3,
    PH_RTS  = 3'd4,
    PH_ILL  = 3'd7
  } phase_e;

  // Short-check thresholds; a zero threshold disables the check (dur < 0 never holds).
  localparam int unsigned RED_LO = (TOL >= RED_CYC) ? 0 : RED_CYC - TOL;
  localparam int unsigned YEL_LO = (TOL >= YEL_CYC) ? 0 : YEL_CYC - TOL;
  localparam int unsigned GRN_LO = (TOL >= GRN_CYC) ? 0 : GRN_CYC - TOL;
  localparam int unsigned RED_HI = RED_CYC + TOL;
  localparam int unsigned YEL_HI = YEL_CYC + TOL;
  localparam int unsigned GRN_HI = GRN_CYC + TOL;

  logic [2:0]    lights_q;
  phase_e        phase_q, phase_d, new_ph;
  logic [CW-1:0] dur_q, dur_d, dur_inc;
  logic          seq_q, seq_d, time_q, time_d, ill_q, ill_d;
  logic          unsynced_q, unsynced_d, reported_q, reported_d;
  logic [2:0]    flags_q, flags_d;
  logic [7:0]    count_q, count_d;
  logic          checked_c;
  logic [CW-1:0] lo_c, hi_c;
  logic          legal_c;
  logic [1:0]    npulse;
  logic [8:0]    cnt_sum;

  // Pattern decode of the sampled lights.
  always_comb begin
    new_ph = PH_ILL;
    unique case (lights_q)
      3'b000:  new_ph = PH_OFF;
      3'b100:  new_ph = PH_STOP;
      3'b110:  new_ph = PH_RTG;
      3'b001:  new_ph = PH_GO;
      3'b010:  new_ph = PH_RTS;
      default: new_ph = PH_ILL;
    endcase
  end

  // Duration window of the phase currently held.
  always_comb begin
    checked_c = 1'b1;
    lo_c      = '0;
    hi_c      = '0;
    unique case (phase_q)
      PH_STOP:       begin lo_c = CW'(RED_LO); hi_c = CW'(RED_HI); end
      PH_RTG, PH_RTS: begin lo_c = CW'(YEL_LO); hi_c = CW'(YEL_HI); end
      PH_GO:         begin lo_c = CW'(GRN_LO); hi_c = CW'(GRN_HI); end
      default:       checked_c = 1'b0;
    endcase
  end

  // Legal successor of the current phase; entering OFF is always allowed.
  always_comb begin
    legal_c = 1'b0;
    if (new_ph == PH_OFF) begin
      legal_c = 1'b1;
    end else begin
      unique case (phase_q)
        PH_OFF:  legal_c = (new_ph == PH_STOP);
        PH_STOP: legal_c = (new_ph == PH_RTG);
        PH_RTG:  legal_c = (new_ph == PH_GO);
        PH_GO:   legal_c = (new_ph == PH_RTS);
        PH_RTS:  legal_c = (new_ph == PH_STOP);
        default: legal_c = 1'b0;
      endcase
    end
  end

  // Phase tracking, error detection and error bookkeeping.
  always_comb begin
    phase_d    = phase_q;
    dur_inc    = (dur_q == '1) ? dur_q : dur_q + CW'(1);
    dur_d      = dur_inc;
    seq_d      = 1'b0;
    time_d     = 1'b0;
    ill_d      = 1'b0;
    unsynced_d = unsynced_q;
    reported_d = reported_q;

    if (new_ph != phase_q) begin
      phase_d    = new_ph;
      dur_d      = CW'(1);
      reported_d = 1'b0;
      // Phase following ILLEGAL has an unknown start, so it is not timed.
      unsynced_d = (phase_q == PH_ILL);
      if (new_ph == PH_ILL) begin
        ill_d = 1'b1;
      end else if (phase_q != PH_ILL && !legal_c) begin
        seq_d = 1'b1;
      end
      if (checked_c && !unsynced_q && !reported_q && (dur_q < lo_c)) begin
        time_d = 1'b1;
      end
    end else if (checked_c && !unsynced_q && !reported_q && (dur_q == hi_c)) begin
      // dur is about to become hi+1: report overrun once.
      time_d     = 1'b1;
      reported_d = 1'b1;
    end

    npulse  = 2'(seq_d) + 2'(time_d) + 2'(ill_d);
    cnt_sum = {1'b0, count_q} + 9'(npulse);
    if (clr) begin
      flags_d = {ill_d, seq_d, time_d};
      count_d = '0;
    end else begin
      flags_d = flags_q | {ill_d, seq_d, time_d};
      count_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lights_q   <= '0;
      phase_q    <= PH_OFF;
      dur_q      <= '0;
      seq_q      <= 1'b0;
      time_q     <= 1'b0;
      ill_q      <= 1'b0;
      unsynced_q <= 1'b0;
      reported_q <= 1'b0;
      flags_q    <= '0;
      count_q    <= '0;
    end else begin
      lights_q   <= {red, yellow, green};
      phase_q    <= phase_d;
      dur_q      <= dur_d;
      seq_q      <= seq_d;
      time_q     <= time_d;
      ill_q      <= ill_d;
      unsynced_q <= unsynced_d;
      reported_q <= reported_d;
      flags_q    <= flags_d;
      count_q    <= count_d;
    end
  end

  assign phase       = phase_q;
  assign dur         = dur_q;
  assign err_seq     = seq_q;
  assign err_time    = time_q;
  assign err_illegal = ill_q;
  assign err_flags   = flags_q;
  assign err_count   = count_q;

endmodule
